// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Writer side of the register bank's single write port. Merges the in-order
// pipeline's WB result (source A, always accepted, highest priority) with
// results from multicycle units (source B) that arrive through a valid/ready
// handshake into a small FIFO. Exports a mask of registers still waiting in the
// FIFO for the hazard unit, and asks the pipeline to stall when B is starved.
//
// Handshake (source B): a transfer happens on every rising edge where
// b_valid && b_ready. b_ready is a function of the registered FIFO count only
// (it is simply !full), so it never depends combinationally on any input, and
// it stays low while full even if the head is popped in that same cycle.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   a_valid/a_addr/a_data   pipeline WB result (a_addr==0 means no request)
//   b_valid/b_ready/b_addr/b_data   multicycle result handshake
//   we/addr_d/data_d  registered write port towards the register bank
//   pending_mask      bit i set while a buffered B entry targets r_i (bit 0 = 0)
//   stall_req         registered request for the pipeline to stop issuing A
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [3:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [3:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        we,
    output logic [3:0]  addr_d,
    output logic [31:0] data_d,
    output logic [15:0] pending_mask,
    output logic        stall_req
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       LIMIT_C = 4'(STARVE_LIMIT);

    // FIFO storage (no reset needed: validity is tracked by count_q)
    logic [3:0]       addr_mem_q [FIFO_DEPTH];
    logic [31:0]      data_mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       starve_q, starve_d;
    logic             stall_q, stall_d;

    logic             wb_we_q, wb_we_d;
    logic [3:0]       wb_addr_q, wb_addr_d;
    logic [31:0]      wb_data_q, wb_data_d;

    logic             push;
    logic             pop;
    logic             a_win;
    logic             fifo_empty;
    logic [3:0]       head_addr;
    logic [31:0]      head_data;

    assign b_ready    = (count_q != DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign head_addr  = addr_mem_q[rd_ptr_q];
    assign head_data  = data_mem_q[rd_ptr_q];

    // A write to r0 is a no-op, so it must not block the FIFO from draining.
    assign a_win = a_valid && (a_addr != 4'd0);
    assign push  = b_valid && b_ready;
    assign pop   = !a_win && !fifo_empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        starve_d  = starve_q;
        wb_we_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Starvation: counts edges where B has data waiting but lost the port.
        if (fifo_empty || pop) begin
            starve_d = 4'd0;
        end else if (starve_q < LIMIT_C) begin
            starve_d = starve_q + 4'd1;
        end

        if (a_win) begin
            wb_we_d   = 1'b1;
            wb_addr_d = a_addr;
            wb_data_d = a_data;
        end else if (pop) begin
            wb_we_d   = (head_addr != 4'd0);
            wb_addr_d = head_addr;
            wb_data_d = head_data;
        end
    end

    // Registered from the current counter, so the request drops one edge after
    // the first pop clears the counter.
    assign stall_d = (starve_q >= LIMIT_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= 4'd0;
            stall_q   <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= 4'd0;
            wb_data_q <= 32'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            addr_mem_q[wr_ptr_q] <= b_addr;
            data_mem_q[wr_ptr_q] <= b_data;
        end
    end

    // Walk the occupied slots starting at the head; only the first count_q
    // slots after rd_ptr_q hold live entries.
    always_comb begin
        pending_mask = 16'd0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (CNT_W'(k) < count_q) begin
                pending_mask[addr_mem_q[rd_ptr_q + PTR_W'(k)]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

    assign we        = wb_we_q;
    assign addr_d    = wb_addr_q;
    assign data_d    = wb_data_q;
    assign stall_req = stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        a_valid;
    logic [3:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [3:0]  b_addr;
    logic [31:0] b_data;
    logic        we;
    logic [3:0]  addr_d;
    logic [31:0] data_d;
    logic [15:0] pending_mask;
    logic        stall_req;

    regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .we(we), .addr_d(addr_d), .data_d(data_d),
        .pending_mask(pending_mask), .stall_req(stall_req)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Buffered B results as {addr, data}, oldest first.
    logic [35:0] exp_q[$];
    logic        m_we;
    logic [3:0]  m_addr;
    logic [31:0] m_data;
    int          m_starve;
    logic        m_stall;

    task automatic model_edge();
        logic        ready;
        logic        a_win;
        logic        do_pop;
        logic [35:0] head;
        if (reset) begin
            exp_q.delete();
            m_we = 0; m_addr = 0; m_data = 0; m_starve = 0; m_stall = 0;
        end else begin
            ready  = (exp_q.size() < DEPTH);
            a_win  = a_valid && (a_addr != 0);
            do_pop = !a_win && (exp_q.size() > 0);
            m_stall = (m_starve >= LIMIT);
            if (exp_q.size() == 0 || do_pop) m_starve = 0;
            else if (m_starve < LIMIT) m_starve = m_starve + 1;
            if (a_win) begin
                m_we = 1; m_addr = a_addr; m_data = a_data;
            end else if (do_pop) begin
                head = exp_q.pop_front();
                m_we = (head[35:32] != 0); m_addr = head[35:32]; m_data = head[31:0];
            end else begin
                m_we = 0;
            end
            if (b_valid && ready) exp_q.push_back({b_addr, b_data});
        end
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] m = 16'd0;
        foreach (exp_q[i]) m[exp_q[i][35:32]] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, ".we"},        32'(we),           32'(m_we));
        chk({tag, ".addr_d"},    32'(addr_d),       32'(m_addr));
        chk({tag, ".data_d"},    data_d,            m_data);
        chk({tag, ".b_ready"},   32'(b_ready),      32'(exp_q.size() < DEPTH));
        chk({tag, ".pend_mask"}, 32'(pending_mask), 32'(model_mask()));
        chk({tag, ".stall_req"}, 32'(stall_req),    32'(m_stall));
        chk({tag, ".no_r0_we"},  32'(we && (addr_d == 4'd0)), 32'd0);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic av, input logic [3:0] aa,
                         input logic [31:0] ad, input logic bv,
                         input logic [3:0] ba, input logic [31:0] bd);
        reset = r; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    // One clock: model commits with the same inputs the DUT sees, then
    // outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        av;
        logic [3:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [3:0]  ba;
        logic [31:0] bd;
        logic        ewe;
        logic [3:0]  eaddr;
        logic [31:0] edata;
        logic        erdy;
        logic [15:0] emask;
        logic        estall;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic av, input logic [3:0] aa,
                       input logic [31:0] ad, input logic bv, input logic [3:0] ba,
                       input logic [31:0] bd, input logic ewe, input logic [3:0] eaddr,
                       input logic [31:0] edata, input logic erdy,
                       input logic [15:0] emask, input logic estall);
        vec_t v;
        v.rst = rst; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
        v.ewe = ewe; v.eaddr = eaddr; v.edata = edata; v.erdy = erdy;
        v.emask = emask; v.estall = estall;
        vecs.push_back(v);
    endtask

    initial begin
        int a_pct;
        drive(1, 0, 0, 0, 0, 0, 0);

        // reset + idle
        add(1,0,0,0,0,0,0,                 0,0,0,1,16'h0000,0);
        for (int i = 0; i < 5; i++)
            add(0,0,0,0,0,0,0,             0,0,0,1,16'h0000,0);
        // A only
        add(0,1,3,32'h12345678,0,0,0,      1,3,32'h12345678,1,16'h0000,0);
        add(0,0,0,0,0,0,0,                 0,3,32'h12345678,1,16'h0000,0);
        // B into empty FIFO
        add(0,0,0,0,1,5,32'hAA,            0,3,32'h12345678,1,16'h0020,0);
        add(0,0,0,0,0,0,0,                 1,5,32'hAA,1,16'h0000,0);
        // starvation with A on r1
        add(0,1,1,32'h11,1,7,32'h70,       1,1,32'h11,1,16'h0080,0);
        add(0,1,1,32'h12,1,9,32'h90,       1,1,32'h12,0,16'h0280,0);
        add(0,1,1,32'h13,0,0,0,            1,1,32'h13,0,16'h0280,0);
        add(0,1,1,32'h14,0,0,0,            1,1,32'h14,0,16'h0280,0);
        add(0,1,1,32'h15,0,0,0,            1,1,32'h15,0,16'h0280,0);
        add(0,1,1,32'h16,0,0,0,            1,1,32'h16,0,16'h0280,1);
        add(0,1,1,32'h17,0,0,0,            1,1,32'h17,0,16'h0280,1);
        add(0,0,0,0,0,0,0,                 1,7,32'h70,1,16'h0200,1);
        add(0,0,0,0,0,0,0,                 1,9,32'h90,1,16'h0000,0);
        add(0,0,0,0,0,0,0,                 0,9,32'h90,1,16'h0000,0);
        // A to r0 lets the FIFO drain; B to r0 pops without a write
        add(0,0,0,0,1,4,32'h44,            0,9,32'h90,1,16'h0010,0);
        add(0,1,0,32'hDEAD,0,0,0,          1,4,32'h44,1,16'h0000,0);
        add(0,0,0,0,1,0,32'h55,            0,4,32'h44,1,16'h0000,0);
        add(0,0,0,0,0,0,0,                 0,0,32'h55,1,16'h0000,0);
        // fill + starve, then reset
        add(0,1,6,32'h60,1,8,32'h80,       1,6,32'h60,1,16'h0100,0);
        add(0,1,6,32'h61,1,10,32'hA0,      1,6,32'h61,0,16'h0500,0);
        add(0,1,6,32'h62,0,0,0,            1,6,32'h62,0,16'h0500,0);
        add(0,1,6,32'h63,0,0,0,            1,6,32'h63,0,16'h0500,0);
        add(0,1,6,32'h64,0,0,0,            1,6,32'h64,0,16'h0500,0);
        add(0,1,6,32'h65,0,0,0,            1,6,32'h65,0,16'h0500,1);
        add(1,0,0,0,0,0,0,                 0,0,0,1,16'h0000,0);
        add(0,0,0,0,1,2,32'h22,            0,0,0,1,16'h0004,0);
        add(0,0,0,0,0,0,0,                 1,2,32'h22,1,16'h0000,0);
        add(0,0,0,0,0,0,0,                 0,2,32'h22,1,16'h0000,0);

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(vecs[i].rst, vecs[i].av, vecs[i].aa, vecs[i].ad,
                  vecs[i].bv, vecs[i].ba, vecs[i].bd);
            step();
            chk({t, ".we"},        32'(we),           32'(vecs[i].ewe));
            chk({t, ".addr_d"},    32'(addr_d),       32'(vecs[i].eaddr));
            chk({t, ".data_d"},    data_d,            vecs[i].edata);
            chk({t, ".b_ready"},   32'(b_ready),      32'(vecs[i].erdy));
            chk({t, ".pend_mask"}, 32'(pending_mask), 32'(vecs[i].emask));
            chk({t, ".stall_req"}, 32'(stall_req),    32'(vecs[i].estall));
        end

        // ---------------- randomized run against the model ----------------
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        check_model("rnd_reset");
        a_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) begin
                case ($urandom_range(3))
                    0: a_pct = 0;
                    1: a_pct = 30;
                    2: a_pct = 70;
                    default: a_pct = 100;
                endcase
            end
            drive(($urandom_range(299) == 0),
                  ($urandom_range(99) < a_pct),
                  4'($urandom_range(15)), $urandom(),
                  1'($urandom_range(1)),
                  4'($urandom_range(15)), $urandom());
            step();
            check_model($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
